// File: rtl/branch_predictor_gshare.sv
// ---------------------------------------------------------------------------
// branch_predictor_gshare
//
// Dual-lane gshare direction predictor. A table of 2^IDX_W saturating
// counters is indexed by the fetch PC XOR-ed with a global history register
// of resolved outcomes. Two lookups per cycle are combinational; up to two
// resolved branches per cycle update the table and the history (lane 1 is
// older than lane 2).
//
// Optional build macro: BPU_STATS_EN adds branch / misprediction counters.
//
// Ports:
//   clk                  rising-edge clock
//   reset                synchronous, active-low
//   pc1, pc2             fetch PCs (word addressed)
//   prediction1/2        taken prediction (counter MSB)
//   pred_idx1/2          table index used for each lookup
//   branch1/2            a resolved conditional branch is presented
//   upd_idx1/2           pred_idx carried down with that branch
//   branch_taken1/2      resolved outcome
//   ghr                  global history, bit 0 = newest outcome
//   upd_pred1/2          (BPU_STATS_EN) prediction carried with the branch
//   stat_branches        (BPU_STATS_EN) resolved branch count, wraps
//   stat_mispred         (BPU_STATS_EN) misprediction count, wraps
// ---------------------------------------------------------------------------
module branch_predictor_gshare #(
  parameter int PC_W  = 11,
  parameter int IDX_W = 5,
  parameter int CNT_W = 2,
  parameter int GHR_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [PC_W-1:0]  pc1,
  input  logic [PC_W-1:0]  pc2,
  output logic             prediction1,
  output logic             prediction2,
  output logic [IDX_W-1:0] pred_idx1,
  output logic [IDX_W-1:0] pred_idx2,
  input  logic             branch1,
  input  logic             branch2,
  input  logic [IDX_W-1:0] upd_idx1,
  input  logic [IDX_W-1:0] upd_idx2,
  input  logic             branch_taken1,
  input  logic             branch_taken2,
`ifdef BPU_STATS_EN
  input  logic             upd_pred1,
  input  logic             upd_pred2,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_mispred,
`endif
  output logic [GHR_W-1:0] ghr
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic taken);
    if (taken) return (c == CNT_MAX) ? c : c + CNT_W'(1);
    else       return (c == '0)      ? c : c - CNT_W'(1);
  endfunction

  logic [CNT_W-1:0] cnt_q [DEPTH];
  logic [CNT_W-1:0] cnt_d [DEPTH];
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // Lookup: reads pre-edge state only, no bypass of same-edge updates.
  assign pred_idx1   = pc1[IDX_W-1:0] ^ IDX_W'(ghr_q);
  assign pred_idx2   = pc2[IDX_W-1:0] ^ IDX_W'(ghr_q);
  assign prediction1 = cnt_q[pred_idx1][CNT_W-1];
  assign prediction2 = cnt_q[pred_idx2][CNT_W-1];
  assign ghr         = ghr_q;

  // Per-entry next state. Lane 2 is applied on top of lane 1's result so a
  // same-index collision composes both outcomes in program order. The hit
  // terms are gated by branchN so an X index on an idle lane cannot leak.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic hit1, hit2;
      logic [CNT_W-1:0] after1;
      assign hit1   = branch1 && (upd_idx1 == IDX_W'(gi));
      assign hit2   = branch2 && (upd_idx2 == IDX_W'(gi));
      assign after1 = hit1 ? sat_step(cnt_q[gi], branch_taken1) : cnt_q[gi];
      assign cnt_d[gi] = hit2 ? sat_step(after1, branch_taken2) : after1;
    end
  endgenerate

  // History shift candidates; short histories need their own forms.
  logic [GHR_W-1:0] ghr_sh1, ghr_sh2, ghr_both;
  generate
    if (GHR_W == 1) begin : g_ghr1
      assign ghr_sh1  = branch_taken1;
      assign ghr_sh2  = branch_taken2;
      assign ghr_both = branch_taken2;
    end else if (GHR_W == 2) begin : g_ghr2
      assign ghr_sh1  = {ghr_q[0], branch_taken1};
      assign ghr_sh2  = {ghr_q[0], branch_taken2};
      assign ghr_both = {branch_taken1, branch_taken2};
    end else begin : g_ghrn
      assign ghr_sh1  = {ghr_q[GHR_W-2:0], branch_taken1};
      assign ghr_sh2  = {ghr_q[GHR_W-2:0], branch_taken2};
      assign ghr_both = {ghr_q[GHR_W-3:0], branch_taken1, branch_taken2};
    end
  endgenerate

  always_comb begin
    ghr_d = ghr_q;
    if (branch1 && branch2) ghr_d = ghr_both;
    else if (branch1)       ghr_d = ghr_sh1;
    else if (branch2)       ghr_d = ghr_sh2;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ghr_q <= '0;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= CNT_WNT;
    end else begin
      ghr_q <= ghr_d;
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BPU_STATS_EN
  logic [31:0] stat_branches_q, stat_mispred_q;
  logic        miss1, miss2;
  assign miss1 = branch1 && (upd_pred1 != branch_taken1);
  assign miss2 = branch2 && (upd_pred2 != branch_taken2);

  always_ff @(posedge clk) begin
    if (!reset) begin
      stat_branches_q <= '0;
      stat_mispred_q  <= '0;
    end else begin
      stat_branches_q <= stat_branches_q + 32'(branch1) + 32'(branch2);
      stat_mispred_q  <= stat_mispred_q + 32'(miss1) + 32'(miss2);
    end
  end

  assign stat_branches = stat_branches_q;
  assign stat_mispred  = stat_mispred_q;
`endif

endmodule
